// File: rtl/neander_loader_pkg.sv
// Shared types and constants for the Neander program loader.
// Optional build macro: NEANDER_LOADER_CHECKSUM_EN (adds the CKSUM frame trailer).
package neander_loader_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_ADDR = 3'd1,
        GET_LEN  = 3'd2,
        DATA     = 3'd3,
        CKSUM    = 3'd4,
        DONE     = 3'd5
    } loader_state_t;

    // A length byte of zero encodes a full-memory (256 byte) image.
    localparam bit LEN_ZERO_MEANS_256 = 1'b1;

    // Running frame sum, modulo 256.
    function automatic logic [7:0] cksum_add(input logic [7:0] sum_i, input logic [7:0] byte_i);
        return sum_i + byte_i;
    endfunction

endpackage

// File: rtl/neander_mem_mux.sv
// RAM write-port mux: the loader owns the port whenever a frame is in progress,
// otherwise the CPU port passes straight through with zero latency.
module neander_mem_mux #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              sel_loader_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_wdata_i,
    input  logic              ld_we_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o
);

    // Select the RAM port owner.
    always_comb begin
        ram_addr_o  = cpu_addr_i;
        ram_wdata_o = cpu_wdata_i;
        ram_we_o    = cpu_we_i;
        if (sel_loader_i) begin
            ram_addr_o  = ld_addr_i;
            ram_wdata_o = ld_wdata_i;
            ram_we_o    = ld_we_i;
        end else begin
            ram_addr_o  = cpu_addr_i;
            ram_wdata_o = cpu_wdata_i;
            ram_we_o    = cpu_we_i;
        end
    end

endmodule

// File: rtl/neander_prog_loader.sv
// Neander program loader: accepts a framed byte stream (addr, len, data[len])
// and writes it into program RAM while holding the CPU in reset.
// Optional build macro: NEANDER_LOADER_CHECKSUM_EN appends a checksum byte to
// the frame; the frame only completes if addr+len+data+checksum == 0 mod 256.
module neander_prog_loader
    import neander_loader_pkg::*;
#(
    parameter bit BOOT_HOLD = 1'b1,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_start,
    input  logic              ld_abort,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] cpu_mem_addr,
    input  logic [DATA_W-1:0] cpu_mem_data_out,
    input  logic              cpu_mem_write,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    loader_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
    logic [LEN_W-1:0]  len_cnt_q, len_cnt_d;
    logic              hold_q, hold_d;
    logic              err_q, err_d;
`ifdef NEANDER_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
`endif

    logic busy_s;
    logic abort_s;
    logic accept_s;
    logic ld_we_s;

    assign busy_s   = (state_q != IDLE);
    assign abort_s  = busy_s && ld_abort;
    assign accept_s = ld_valid && ld_ready;
    // An abort suppresses the write of the byte presented alongside it.
    assign ld_we_s  = (state_q == DATA) && ld_valid && !ld_abort;

    // Decode stream readiness from the current state.
    always_comb begin
        ld_ready = 1'b0;
        case (state_q)
            GET_ADDR: ld_ready = 1'b1;
            GET_LEN:  ld_ready = 1'b1;
            DATA:     ld_ready = 1'b1;
`ifdef NEANDER_LOADER_CHECKSUM_EN
            CKSUM:    ld_ready = 1'b1;
`endif
            default:  ld_ready = 1'b0;
        endcase
    end

    // Next-state and counter logic for the frame sequencer.
    always_comb begin
        state_d    = state_q;
        addr_cnt_d = addr_cnt_q;
        len_cnt_d  = len_cnt_q;
        hold_d     = hold_q;
        err_d      = err_q;
`ifdef NEANDER_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (abort_s) begin
            // Abandon the frame; the CPU stays held on the partial image.
            state_d = IDLE;
            err_d   = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld_start) begin
                        state_d = GET_ADDR;
                        hold_d  = 1'b1;
                        err_d   = 1'b0;
`ifdef NEANDER_LOADER_CHECKSUM_EN
                        sum_d   = {DATA_W{1'b0}};
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                GET_ADDR: begin
                    if (accept_s) begin
                        addr_cnt_d = ld_data;
                        state_d    = GET_LEN;
`ifdef NEANDER_LOADER_CHECKSUM_EN
                        sum_d      = cksum_add(sum_q, ld_data);
`endif
                    end else begin
                        state_d = GET_ADDR;
                    end
                end
                GET_LEN: begin
                    if (accept_s) begin
                        if (LEN_ZERO_MEANS_256 && (ld_data == {DATA_W{1'b0}})) begin
                            len_cnt_d = LEN_FULL;
                        end else begin
                            len_cnt_d = {1'b0, ld_data};
                        end
                        state_d = DATA;
`ifdef NEANDER_LOADER_CHECKSUM_EN
                        sum_d   = cksum_add(sum_q, ld_data);
`endif
                    end else begin
                        state_d = GET_LEN;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        addr_cnt_d = addr_cnt_q + ADDR_ONE;
                        len_cnt_d  = len_cnt_q - LEN_ONE;
`ifdef NEANDER_LOADER_CHECKSUM_EN
                        sum_d      = cksum_add(sum_q, ld_data);
`endif
                        if (len_cnt_q == LEN_ONE) begin
`ifdef NEANDER_LOADER_CHECKSUM_EN
                            state_d = CKSUM;
`else
                            state_d = DONE;
`endif
                        end else begin
                            state_d = DATA;
                        end
                    end else begin
                        state_d = DATA;
                    end
                end
`ifdef NEANDER_LOADER_CHECKSUM_EN
                CKSUM: begin
                    if (accept_s) begin
                        if (cksum_add(sum_q, ld_data) == {DATA_W{1'b0}}) begin
                            state_d = DONE;
                        end else begin
                            state_d = IDLE;
                            err_d   = 1'b1;
                        end
                    end else begin
                        state_d = CKSUM;
                    end
                end
`endif
                DONE: begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Sequencer state, counters, CPU hold and sticky error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            addr_cnt_q <= {ADDR_W{1'b0}};
            len_cnt_q  <= {LEN_W{1'b0}};
            hold_q     <= BOOT_HOLD;
            err_q      <= 1'b0;
`ifdef NEANDER_LOADER_CHECKSUM_EN
            sum_q      <= {DATA_W{1'b0}};
`endif
        end else begin
            state_q    <= state_d;
            addr_cnt_q <= addr_cnt_d;
            len_cnt_q  <= len_cnt_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
`ifdef NEANDER_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign busy      = busy_s;
    assign done      = (state_q == DONE) && !ld_abort;
    assign err       = err_q;
    assign cpu_reset = reset | hold_q;

    neander_mem_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem_mux (
        .sel_loader_i (busy_s),
        .cpu_addr_i   (cpu_mem_addr),
        .cpu_wdata_i  (cpu_mem_data_out),
        .cpu_we_i     (cpu_mem_write),
        .ld_addr_i    (addr_cnt_q),
        .ld_wdata_i   (ld_data),
        .ld_we_i      (ld_we_s),
        .ram_addr_o   (ram_addr),
        .ram_wdata_o  (ram_wdata),
        .ram_we_o     (ram_we)
    );

endmodule

// File: tb/tb_neander_prog_loader.sv
// Directed bench for neander_prog_loader: idle pass-through table plus
// hand-written frame sequences (normal, wrap, len 0, gaps, abort, reset).
module tb_neander_prog_loader;

    logic       clk = 1'b0;
    logic       reset;
    logic       ld_start, ld_abort, ld_valid;
    logic [7:0] ld_data;
    logic [7:0] cpu_mem_addr, cpu_mem_data_out;
    logic       cpu_mem_write;

    logic       ld_ready, ram_we, cpu_reset, busy, done, err;
    logic [7:0] ram_addr, ram_wdata;
    logic       r0_ld_ready, r0_ram_we, r0_cpu_reset, r0_busy, r0_done, r0_err;
    logic [7:0] r0_ram_addr, r0_ram_wdata;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:255];
    int         wr_cnt = 0;
    int         done_cnt = 0;
    logic [7:0] wr_log [$];
    logic [7:0] data_q [$];

    always #5 clk = ~clk;

    neander_prog_loader #(.BOOT_HOLD(1'b1)) dut (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_abort(ld_abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_data_out(cpu_mem_data_out),
        .cpu_mem_write(cpu_mem_write), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err)
    );

    neander_prog_loader #(.BOOT_HOLD(1'b0)) dut0 (
        .clk(clk), .reset(reset), .ld_start(ld_start), .ld_abort(ld_abort),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(r0_ld_ready),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_data_out(cpu_mem_data_out),
        .cpu_mem_write(cpu_mem_write), .ram_addr(r0_ram_addr), .ram_wdata(r0_ram_wdata),
        .ram_we(r0_ram_we), .cpu_reset(r0_cpu_reset), .busy(r0_busy), .done(r0_done),
        .err(r0_err)
    );

    // RAM model and write/done observers for the BOOT_HOLD=1 instance.
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_cnt        <= wr_cnt + 1;
            wr_log.push_back(ram_addr);
        end
        if (done) begin
            done_cnt <= done_cnt + 1;
        end
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
        logic       we;
        logic [7:0] exp_a;
        logic [7:0] exp_d;
        logic       exp_we;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic start_frame();
        @(negedge clk);
        ld_start = 1'b1;
        @(posedge clk);
        #1;
        ld_start = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        ld_valid = 1'b1;
        ld_data  = b;
        #1;
        while (!ld_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("push_ready", ld_ready, 1);
        @(posedge clk);
        #1;
        ld_valid = 1'b0;
    endtask

    // Sends addr, len, data_q (and checksum when enabled); returns in DONE.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] l, input bit gaps);
        logic [7:0] s;
        s = a + l;
        start_frame();
        push(a);
        push(l);
        for (int i = 0; i < data_q.size(); i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            push(data_q[i]);
            s = s + data_q[i];
        end
`ifdef NEANDER_LOADER_CHECKSUM_EN
        push(8'h00 - s);
`endif
    endtask

    task automatic check_done_then_idle(input string nm, input int d0);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_hold_in_done"}, cpu_reset, 1);
        @(posedge clk);
        #1;
        chk({nm, "_done_low"}, done, 0);
        chk({nm, "_busy_low"}, busy, 0);
        chk({nm, "_cpu_release"}, cpu_reset, 0);
        chk({nm, "_done_once"}, done_cnt - d0, 1);
    endtask

    initial begin
        vec_t vt [4];
        int w0, d0, l0;

        vt[0] = '{8'h80, 8'h5A, 1'b1, 8'h80, 8'h5A, 1'b1};
        vt[1] = '{8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF, 1'b1};
        vt[2] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b0};
        vt[3] = '{8'h3C, 8'hC3, 1'b1, 8'h3C, 8'hC3, 1'b1};

        reset = 1'b1; ld_start = 1'b0; ld_abort = 1'b0; ld_valid = 1'b0; ld_data = 8'h00;
        cpu_mem_addr = 8'h00; cpu_mem_data_out = 8'h00; cpu_mem_write = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cpu_reset", cpu_reset, 1);
        chk("rst_cpu_reset_bh0", r0_cpu_reset, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", ld_ready, 0);
        chk("rst_we", ram_we, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("boot_hold1", cpu_reset, 1);
        chk("boot_hold0", r0_cpu_reset, 0);

        // Idle pass-through table
        for (int i = 0; i < 4; i++) begin
            cpu_mem_addr = vt[i].a; cpu_mem_data_out = vt[i].d; cpu_mem_write = vt[i].we;
            #1;
            chk("pt_addr", ram_addr, vt[i].exp_a);
            chk("pt_wdata", ram_wdata, vt[i].exp_d);
            chk("pt_we", ram_we, vt[i].exp_we);
            chk("pt0_addr", r0_ram_addr, vt[i].exp_a);
            chk("pt0_wdata", r0_ram_wdata, vt[i].exp_d);
            chk("pt0_we", r0_ram_we, vt[i].exp_we);
        end
        cpu_mem_write = 1'b0;
        #1;
        chk("idle_no_we", ram_we, 0);
        @(negedge clk);
        chk("still_held", cpu_reset, 1);

        // Basic frame
        w0 = wr_cnt; d0 = done_cnt; l0 = wr_log.size();
        data_q = '{8'h20, 8'h30, 8'h40};
        send_frame(8'h10, 8'h03, 1'b0);
        check_done_then_idle("f1", d0);
        chk("f1_writes", wr_cnt - w0, 3);
        chk("f1_m10", mem[8'h10], 8'h20);
        chk("f1_m11", mem[8'h11], 8'h30);
        chk("f1_m12", mem[8'h12], 8'h40);
        chk("f1_order0", wr_log[l0], 8'h10);
        chk("f1_order2", wr_log[l0 + 2], 8'h12);

        // Address wrap
        w0 = wr_cnt; d0 = done_cnt; l0 = wr_log.size();
        data_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_frame(8'hFE, 8'h04, 1'b0);
        check_done_then_idle("wrap", d0);
        chk("wrap_writes", wr_cnt - w0, 4);
        chk("wrap_a0", wr_log[l0], 8'hFE);
        chk("wrap_a1", wr_log[l0 + 1], 8'hFF);
        chk("wrap_a2", wr_log[l0 + 2], 8'h00);
        chk("wrap_a3", wr_log[l0 + 3], 8'h01);
        chk("wrap_m00", mem[8'h00], 8'hA2);

        // Length 0 means 256 bytes
        w0 = wr_cnt; d0 = done_cnt;
        data_q.delete();
        for (int i = 0; i < 256; i++) data_q.push_back(8'(i) ^ 8'h5A);
        send_frame(8'h40, 8'h00, 1'b0);
        check_done_then_idle("len0", d0);
        chk("len0_writes", wr_cnt - w0, 256);
        chk("len0_m40", mem[8'h40], 8'h5A);
        chk("len0_m3f", mem[8'h3F], 8'hA5);

        // Gaps in ld_valid with CPU writes attempted during the frame
        w0 = wr_cnt; d0 = done_cnt;
        data_q = '{8'hB1, 8'hB2, 8'hB3, 8'hB4};
        cpu_mem_addr = 8'h82; cpu_mem_data_out = 8'hEE;
        fork
            begin
                @(negedge clk);
                @(negedge clk);
                cpu_mem_write = 1'b1;
            end
        join_none
        send_frame(8'h80, 8'h04, 1'b1);
        cpu_mem_write = 1'b0;
        check_done_then_idle("gap", d0);
        chk("gap_writes", wr_cnt - w0, 4);
        chk("gap_m80", mem[8'h80], 8'hB1);
        chk("gap_m82", mem[8'h82], 8'hB3);
        chk("gap_m83", mem[8'h83], 8'hB4);

        // Abort after two data bytes
        w0 = wr_cnt; d0 = done_cnt;
        start_frame();
        push(8'h30);
        push(8'h05);
        push(8'h11);
        push(8'h22);
        @(negedge clk);
        ld_abort = 1'b1; ld_valid = 1'b1; ld_data = 8'h99;
        #1;
        chk("abort_no_we", ram_we, 0);
        @(posedge clk);
        #1;
        ld_abort = 1'b0; ld_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_err", err, 1);
        chk("abort_hold", cpu_reset, 1);
        chk("abort_writes", wr_cnt - w0, 2);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_err_sticky", err, 1);
        @(negedge clk);
        ld_abort = 1'b1;
        @(posedge clk);
        #1;
        ld_abort = 1'b0;
        chk("idle_abort_noop", busy, 0);
        start_frame();
        chk("start_clears_err", err, 0);
        chk("start_busy", busy, 1);
        @(negedge clk);
        ld_abort = 1'b1;
        @(posedge clk);
        #1;
        ld_abort = 1'b0;

`ifdef NEANDER_LOADER_CHECKSUM_EN
        // Checksum mismatch then match
        d0 = done_cnt;
        start_frame();
        push(8'h00);
        push(8'h01);
        push(8'h05);
        push(8'hFB);
        chk("ck_bad_busy", busy, 0);
        chk("ck_bad_err", err, 1);
        chk("ck_bad_hold", cpu_reset, 1);
        chk("ck_bad_no_done", done_cnt - d0, 0);
        start_frame();
        push(8'h00);
        push(8'h01);
        push(8'h05);
        push(8'hFA);
        check_done_then_idle("ck_ok", d0);
        chk("ck_ok_err", err, 0);
        chk("ck_ok_m00", mem[8'h00], 8'h05);
`endif

        // Reset mid-frame
        start_frame();
        push(8'h55);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cpu_reset", cpu_reset, 1);
        chk("mid_rst_ready", ld_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_hold1", cpu_reset, 1);
        chk("mid_rst_hold0", r0_cpu_reset, 0);
        chk("mid_rst_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
